// File: rtl/multicycle_controller_pkg.sv
// Shared definitions for the multicycle controller: state encoding, opcode/funct
// constants and the 3-bit ALU operation codes (also used by the ALU itself).
package multicycle_controller_pkg;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_I_EXEC    = 4'd8,
        S_I_WB      = 4'd9,
        S_BRANCH    = 4'd10,
        S_JUMP      = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b010;
    localparam logic [2:0] ALU_BEQ = 3'b011;
    localparam logic [2:0] ALU_BNE = 3'b100;

    // Unknown opcodes return to FETCH, making them a two-cycle no-op.
    function automatic state_t decode_target(input logic [5:0] opcode);
        case (opcode)
            OP_LW, OP_SW:     return S_MEM_ADDR;
            OP_RTYPE:         return S_R_EXEC;
            OP_ADDI, OP_SLTI: return S_I_EXEC;
            OP_BEQ, OP_BNE:   return S_BRANCH;
            OP_J:             return S_JUMP;
            default:          return S_FETCH;
        endcase
    endfunction

endpackage

// File: rtl/mc_alu_decode.sv
// Combinational ALU operation select from controller state, opcode and funct.
module mc_alu_decode
    import multicycle_controller_pkg::*;
(
    input  state_t      state,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    output logic [2:0]  alu_func
);

    always_comb begin
        alu_func = ALU_ADD;
        case (state)
            S_R_EXEC: begin
                case (funct)
                    FN_SUB:  alu_func = ALU_SUB;
                    FN_SLT:  alu_func = ALU_SLT;
                    default: alu_func = ALU_ADD;
                endcase
            end
            S_I_EXEC: alu_func = (opcode == OP_SLTI) ? ALU_SLT : ALU_ADD;
            S_BRANCH: alu_func = (opcode == OP_BNE) ? ALU_BNE : ALU_BEQ;
            default:  alu_func = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Moore-style control FSM for a multicycle MIPS-like datapath; outputs decode
// from the state register, with mem_ready/zero feeding the handshake strobes.
module multicycle_controller
    import multicycle_controller_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic        iord,
    output logic        mem_read,
    output logic        mem_write,
    output logic        ir_write,
    output logic        reg_dst,
    output logic        mem_to_reg,
    output logic        reg_write,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  pc_src,
    output logic [2:0]  alu_func
);

    state_t state_reg;
    state_t state_next;

    logic pc_write_dec;
    logic mem_read_dec;
    logic mem_write_dec;
    logic ir_write_dec;
    logic reg_write_dec;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= S_FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_FETCH:     if (mem_ready) state_next = S_DECODE;
            S_DECODE:    state_next = decode_target(opcode);
            S_MEM_ADDR:  state_next = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            S_MEM_READ:  if (mem_ready) state_next = S_MEM_WB;
            S_MEM_WRITE: if (mem_ready) state_next = S_FETCH;
            S_R_EXEC:    state_next = S_R_WB;
            S_I_EXEC:    state_next = S_I_WB;
            default:     state_next = S_FETCH;
        endcase
    end

    always_comb begin
        pc_write_dec  = 1'b0;
        iord          = 1'b0;
        mem_read_dec  = 1'b0;
        mem_write_dec = 1'b0;
        ir_write_dec  = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write_dec = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        pc_src        = 2'b00;
        case (state_reg)
            S_FETCH: begin
                mem_read_dec = 1'b1;
                alu_src_b    = 2'b01;
                ir_write_dec = mem_ready;
                pc_write_dec = mem_ready;
            end
            S_DECODE:   alu_src_b = 2'b11;
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEM_READ: begin
                iord         = 1'b1;
                mem_read_dec = 1'b1;
            end
            S_MEM_WB: begin
                mem_to_reg    = 1'b1;
                reg_write_dec = 1'b1;
            end
            S_MEM_WRITE: begin
                iord          = 1'b1;
                mem_write_dec = 1'b1;
            end
            S_R_EXEC: alu_src_a = 1'b1;
            S_R_WB: begin
                reg_dst       = 1'b1;
                reg_write_dec = 1'b1;
            end
            S_I_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_I_WB: reg_write_dec = 1'b1;
            S_BRANCH: begin
                alu_src_a    = 1'b1;
                pc_src       = 2'b01;
                pc_write_dec = ~zero;
            end
            S_JUMP: begin
                pc_src       = 2'b10;
                pc_write_dec = 1'b1;
            end
            default: ;
        endcase
    end

    // Strobes are masked directly by rst so a FETCH-in-reset never writes IR/PC.
    assign pc_write  = pc_write_dec  & ~rst;
    assign mem_read  = mem_read_dec  & ~rst;
    assign mem_write = mem_write_dec & ~rst;
    assign ir_write  = ir_write_dec  & ~rst;
    assign reg_write = reg_write_dec & ~rst;

    mc_alu_decode u_alu_decode (
        .state    (state_reg),
        .opcode   (opcode),
        .funct    (funct),
        .alu_func (alu_func)
    );

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized instruction-stream bench; expected controls come from a per-phase
// table built from each instruction class.
module tb_multicycle_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        zero;
    logic        mem_ready;
    logic        pc_write, iord, mem_read, mem_write, ir_write;
    logic        reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic [1:0]  alu_src_b, pc_src;
    logic [2:0]  alu_func;

    int checks   = 0;
    int failures = 0;

    typedef enum int {C_LW, C_SW, C_R, C_ADDI, C_SLTI, C_BEQ, C_BNE, C_J, C_ILL} cls_e;
    typedef enum int {P_FETCH, P_DECODE, P_ADDR, P_MEMRD, P_MEMWB, P_MEMWR,
                      P_REXEC, P_RWB, P_IEXEC, P_IWB, P_BR, P_JMP} ph_e;

    typedef struct packed {
        logic       pc_write;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
        logic [2:0] alu_func;
    } ctl_t;

    logic [15:0] dut_vec;
    assign dut_vec = {pc_write, iord, mem_read, mem_write, ir_write, reg_dst,
                      mem_to_reg, reg_write, alu_src_a, alu_src_b, pc_src, alu_func};

    multicycle_controller dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .funct      (funct),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .pc_write   (pc_write),
        .iord       (iord),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .ir_write   (ir_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .reg_write  (reg_write),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .pc_src     (pc_src),
        .alu_func   (alu_func)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [5:0] opcode_for(input cls_e cls);
        logic [5:0] op;
        case (cls)
            C_LW:   op = 6'b100011;
            C_SW:   op = 6'b101011;
            C_R:    op = 6'b000000;
            C_ADDI: op = 6'b001000;
            C_SLTI: op = 6'b001010;
            C_BEQ:  op = 6'b000100;
            C_BNE:  op = 6'b000101;
            C_J:    op = 6'b000010;
            default: begin
                op = 6'b111111;
                if ($urandom_range(0, 1) == 1) begin
                    do op = 6'($urandom_range(0, 63));
                    while (op inside {6'b100011, 6'b101011, 6'b000000, 6'b001000,
                                      6'b001010, 6'b000100, 6'b000101, 6'b000010});
                end
            end
        endcase
        return op;
    endfunction

    // Expected control word for one phase of an instruction.
    function automatic logic [15:0] model(input ph_e ph, input logic [5:0] op,
                                          input logic [5:0] fn, input logic z, input logic rdy);
        ctl_t c;
        c = '0;
        case (ph)
            P_FETCH:  begin c.mem_read = 1; c.alu_src_b = 2'b01; c.ir_write = rdy; c.pc_write = rdy; end
            P_DECODE: c.alu_src_b = 2'b11;
            P_ADDR:   begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
            P_MEMRD:  begin c.iord = 1; c.mem_read = 1; end
            P_MEMWB:  begin c.mem_to_reg = 1; c.reg_write = 1; end
            P_MEMWR:  begin c.iord = 1; c.mem_write = 1; end
            P_REXEC: begin
                c.alu_src_a = 1;
                c.alu_func  = (fn == 6'b100010) ? 3'b001 : (fn == 6'b101010) ? 3'b010 : 3'b000;
            end
            P_RWB:    begin c.reg_dst = 1; c.reg_write = 1; end
            P_IEXEC: begin
                c.alu_src_a = 1; c.alu_src_b = 2'b10;
                c.alu_func  = (op == 6'b001010) ? 3'b010 : 3'b000;
            end
            P_IWB:    c.reg_write = 1;
            P_BR: begin
                c.alu_src_a = 1; c.pc_src = 2'b01; c.pc_write = ~z;
                c.alu_func  = (op == 6'b000101) ? 3'b100 : 3'b011;
            end
            P_JMP:    begin c.pc_src = 2'b10; c.pc_write = 1; end
            default: ;
        endcase
        return c;
    endfunction

    // Runs one instruction starting at a negedge and returns at a negedge.
    // abort_mode 1: hold reset across an edge during the lw read stall; 2: short pulse.
    task automatic run_instr(input cls_e cls, input int abort_mode);
        ph_e        q[$];
        logic [5:0] op;
        logic [5:0] fn;
        int         stalls;
        bit         stay;
        op = opcode_for(cls);
        case ($urandom_range(0, 3))
            0: fn = 6'b100000;
            1: fn = 6'b100010;
            2: fn = 6'b101010;
            default: fn = 6'($urandom_range(0, 63));
        endcase
        q = '{P_FETCH, P_DECODE};
        case (cls)
            C_LW:           q = {q, P_ADDR, P_MEMRD, P_MEMWB};
            C_SW:           q = {q, P_ADDR, P_MEMWR};
            C_R:            q = {q, P_REXEC, P_RWB};
            C_ADDI, C_SLTI: q = {q, P_IEXEC, P_IWB};
            C_BEQ, C_BNE:   q = {q, P_BR};
            C_J:            q = {q, P_JMP};
            default: ;
        endcase
        foreach (q[i]) begin
            stalls = 0;
            do begin
                mem_ready = ($urandom_range(0, 2) != 0) || (stalls >= 4);
                zero      = 1'($urandom_range(0, 1));
                opcode    = op;
                funct     = fn;
                if (abort_mode != 0 && q[i] == P_MEMRD) mem_ready = 1'b0;
                #1;
                check($sformatf("%s.%s", cls.name(), q[i].name()), dut_vec,
                      model(q[i], op, fn, zero, mem_ready));
                check("excl", {14'd0, mem_read & mem_write, pc_write & reg_write}, 16'd0);
                if (abort_mode == 1 && q[i] == P_MEMRD) begin
                    #2 rst = 1'b1;
                    mem_ready = 1'b1;
                    #1;
                    check("rst_async", {9'd0, pc_write, ir_write, reg_write, mem_write,
                                        mem_read, iord, alu_src_b == 2'b01}, 16'd1);
                    @(negedge clk);
                    check("rst_held", {9'd0, pc_write, ir_write, reg_write, mem_write,
                                       mem_read, iord, alu_src_b == 2'b01}, 16'd1);
                    rst = 1'b0;
                    return;
                end
                if (abort_mode == 2 && q[i] == P_MEMRD) begin
                    #1 rst = 1'b1;
                    #1 rst = 1'b0;
                    #1;
                    check("rst_pulse", dut_vec, model(P_FETCH, op, fn, zero, mem_ready));
                    @(negedge clk);
                    return;
                end
                stay = (q[i] inside {P_FETCH, P_MEMRD, P_MEMWR}) && !mem_ready;
                stalls++;
                @(negedge clk);
            end while (stay);
        end
    endtask

    initial begin
        rst       = 1'b1;
        mem_ready = 1'b1;
        zero      = 1'b0;
        opcode    = 6'd0;
        funct     = 6'd0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_init", {11'd0, pc_write, ir_write, reg_write, mem_write, mem_read}, 16'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c <= int'(C_ILL); c++) run_instr(cls_e'(c), 0);
        run_instr(C_LW, 1);
        run_instr(C_R, 0);
        run_instr(C_LW, 2);
        run_instr(C_SW, 0);
        for (int n = 0; n < 300; n++) run_instr(cls_e'($urandom_range(0, int'(C_ILL))), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
